md5_search_sequencer: RTL and testbench

Sequences the lane-parallel MD5 brute-force datapath. The block issues one base candidate per cycle to LANES free-running hash pipelines, where the lane index supplies the low bits. It keeps a LATENCY-deep tag history so that each pipeline found pulse is matched to the exact candidate that produced it. After the last issue it drains the pipelines before declaring not-found, then reports the result over a valid/ready handshake.

---
 rtl/md5_search_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_md5_search_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_search_sequencer.sv
// Issue sequencer for the lane-parallel MD5 brute-force search. Tags every issue in a
// LATENCY-deep ring so each pipeline found pulse resolves to the exact candidate.
module md5_search_sequencer #(
    parameter int unsigned LATENCY = 64,
    parameter int unsigned BASE_W  = 29,
    parameter int unsigned LANES   = 8,
    parameter int unsigned LANE_W  = 3
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              enable_i,
    input  logic [LANES-1:0]  found_vec_i,
    output logic [BASE_W-1:0] base_out_o,
    output logic              issue_valid_o,
    output logic              busy_o,
    output logic              paused_o,
    output logic              draining_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              result_hit_o,
    output logic [31:0]       result_candidate_o,
    output logic              multi_hit_o,
    output logic [7:0]        spurious_cnt_o
);

    localparam int unsigned PtrW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StPause,
        StDrain,
        StReport,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic              issue_q, issue_d;
    logic [PtrW-1:0]   drain_q, drain_d;
    logic              hit_q, hit_d;
    logic [31:0]       cand_q, cand_d;
    logic              multi_q, multi_d;
    logic [7:0]        spur_q, spur_d;
    logic              busy_q, busy_d;
    logic              paused_q, paused_d;
    logic              draining_q, draining_d;
    logic              rvalid_q, rvalid_d;

    logic [PtrW-1:0]    wp_q;
    logic [LATENCY-1:0] valid_q;
    logic [BASE_W-1:0]  hist_q [LATENCY];

    logic              tag_valid;
    logic [BASE_W-1:0] tag_base;
    logic              active;
    logic              any_found;
    logic              tagged_hit;
    logic              spurious;
    logic [LANE_W-1:0] lane_idx;
    logic              multi_found;
    logic [31:0]       hit_cand;
    logic              last_base;
    logic              drain_done;

    // The slot at wp was written exactly LATENCY cycles ago, so it tags this cycle's found_vec.
    always_comb begin
        tag_valid   = valid_q[wp_q];
        tag_base    = hist_q[wp_q];
        active      = (state_q == StRun) || (state_q == StPause) || (state_q == StDrain);
        any_found   = |found_vec_i;
        tagged_hit  = active && any_found && tag_valid;
        spurious    = active && any_found && !tag_valid;
        lane_idx    = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (found_vec_i[i]) begin
                lane_idx = LANE_W'(i);
            end
        end
        multi_found = |(found_vec_i & (found_vec_i - LANES'(1)));
        hit_cand    = '0;
        hit_cand[BASE_W+LANE_W-1:0] = {tag_base, lane_idx};
        last_base   = &base_q;
        drain_done  = (drain_q == PtrW'(LATENCY - 1));
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        issue_d = issue_q;
        drain_d = drain_q;
        hit_d   = hit_q;
        cand_d  = cand_q;
        multi_d = multi_q;
        spur_d  = spur_q;

        if (spurious && (spur_q != 8'hFF)) begin
            spur_d = spur_q + 8'd1;
        end

        case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d = StRun;
                    issue_d = 1'b1;
                    base_d  = '0;
                end
            end
            StRun: begin
                if (last_base) begin
                    state_d = StDrain;
                    issue_d = 1'b0;
                    drain_d = '0;
                end else if (!enable_i) begin
                    state_d = StPause;
                    issue_d = 1'b0;
                    base_d  = base_q + BASE_W'(1);
                end else begin
                    base_d  = base_q + BASE_W'(1);
                end
            end
            StPause: begin
                if (enable_i) begin
                    state_d = StRun;
                    issue_d = 1'b1;
                end
            end
            StDrain: begin
                drain_d = drain_q + PtrW'(1);
                if (drain_done) begin
                    state_d = StReport;
                    hit_d   = 1'b0;
                    cand_d  = '0;
                    multi_d = 1'b0;
                end
            end
            StReport: begin
                if (result_ready_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!enable_i) begin
                    state_d = StIdle;
                    base_d  = '0;
                    hit_d   = 1'b0;
                    cand_d  = '0;
                    multi_d = 1'b0;
                    spur_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A tagged hit outranks exhaustion and pause in the same cycle.
        if (tagged_hit) begin
            state_d = StReport;
            issue_d = 1'b0;
            hit_d   = 1'b1;
            cand_d  = hit_cand;
            multi_d = multi_found;
        end

        busy_d     = (state_d == StRun) || (state_d == StPause) || (state_d == StDrain);
        paused_d   = (state_d == StPause);
        draining_d = (state_d == StDrain);
        rvalid_d   = (state_d == StReport);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            issue_q    <= 1'b0;
            drain_q    <= '0;
            hit_q      <= 1'b0;
            cand_q     <= '0;
            multi_q    <= 1'b0;
            spur_q     <= '0;
            busy_q     <= 1'b0;
            paused_q   <= 1'b0;
            draining_q <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            issue_q    <= issue_d;
            drain_q    <= drain_d;
            hit_q      <= hit_d;
            cand_q     <= cand_d;
            multi_q    <= multi_d;
            spur_q     <= spur_d;
            busy_q     <= busy_d;
            paused_q   <= paused_d;
            draining_q <= draining_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Clearing the valid bits on reset retires every in-flight tag at once.
    always_ff @(posedge CLK) begin
        if (reset) begin
            valid_q <= '0;
            wp_q    <= '0;
        end else begin
            valid_q[wp_q] <= issue_q;
            wp_q          <= (wp_q == PtrW'(LATENCY - 1)) ? '0 : wp_q + PtrW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            hist_q[wp_q] <= base_q;
        end
    end

    assign base_out_o         = base_q;
    assign issue_valid_o      = issue_q;
    assign busy_o             = busy_q;
    assign paused_o           = paused_q;
    assign draining_o         = draining_q;
    assign result_valid_o     = rvalid_q;
    assign result_hit_o       = hit_q;
    assign result_candidate_o = cand_q;
    assign multi_hit_o        = multi_q;
    assign spurious_cnt_o     = spur_q;

endmodule

// File: tb/tb_md5_search_sequencer.sv
// Directed bench for md5_search_sequencer with a short pipeline (LATENCY=4) and a 4-bit base
// so exhaustion and drain are reachable in a few dozen cycles.
module tb_md5_search_sequencer;

    localparam int unsigned LAT = 4;
    localparam int unsigned BW  = 4;
    localparam int unsigned LN  = 8;
    localparam int unsigned LW  = 3;

    logic          CLK = 1'b0;
    logic          reset;
    logic          enable;
    logic [LN-1:0] found_vec;
    logic [BW-1:0] base_out;
    logic          issue_valid;
    logic          busy;
    logic          paused;
    logic          draining;
    logic          result_valid;
    logic          result_ready;
    logic          result_hit;
    logic [31:0]   result_candidate;
    logic          multi_hit;
    logic [7:0]    spurious_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    md5_search_sequencer #(
        .LATENCY(LAT),
        .BASE_W (BW),
        .LANES  (LN),
        .LANE_W (LW)
    ) dut (
        .CLK               (CLK),
        .reset             (reset),
        .enable_i          (enable),
        .found_vec_i       (found_vec),
        .base_out_o        (base_out),
        .issue_valid_o     (issue_valid),
        .busy_o            (busy),
        .paused_o          (paused),
        .draining_o        (draining),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .result_hit_o      (result_hit),
        .result_candidate_o(result_candidate),
        .multi_hit_o       (multi_hit),
        .spurious_cnt_o    (spurious_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        found_vec    = '0;
        result_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_issue(input logic [BW-1:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (issue_valid && base_out == b) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({busy, paused, draining, result_valid, issue_valid, result_hit, multi_hit} !== 7'b0)
            $display("FAIL reset_flags: got %b want 0000000",
                     {busy, paused, draining, result_valid, issue_valid, result_hit, multi_hit});
        else n_pass++;
        n_checks++;
        if (base_out !== 4'd0) $display("FAIL reset_base: got %0d want 0", base_out);
        else n_pass++;
        n_checks++;
        if (result_candidate !== 32'd0 || spurious_cnt !== 8'd0)
            $display("FAIL reset_result: cand %h spur %0d want 0 0", result_candidate, spurious_cnt);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b0 || issue_valid !== 1'b0)
            $display("FAIL idle_hold: busy %b issue %b want 0 0", busy, issue_valid);
        else n_pass++;
    endtask

    task automatic test_hit_single();
        bit ok;
        apply_reset();
        enable = 1'b1;
        step();
        wait_issue(4'd5, ok);
        n_checks++;
        if (!ok) $display("FAIL hit1_issue_timeout: base 5 never issued");
        else n_pass++;
        repeat (4) step();
        found_vec = 8'b0000_0100;
        step();
        found_vec = '0;
        n_checks++;
        if (result_valid !== 1'b1 || result_hit !== 1'b1 || result_candidate !== 32'h0000_002A ||
            multi_hit !== 1'b0)
            $display("FAIL hit1_result: valid %b hit %b cand %h multi %b want 1 1 0000002a 0",
                     result_valid, result_hit, result_candidate, multi_hit);
        else n_pass++;
        n_checks++;
        if (issue_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL hit1_stop: issue %b busy %b want 0 0", issue_valid, busy);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (result_valid !== 1'b1 || result_candidate !== 32'h0000_002A)
                $display("FAIL hit1_hold: valid %b cand %h want 1 0000002a",
                         result_valid, result_candidate);
            else n_pass++;
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        n_checks++;
        if (result_valid !== 1'b0 || result_hit !== 1'b1 || result_candidate !== 32'h0000_002A)
            $display("FAIL hit1_done: valid %b hit %b cand %h want 0 1 0000002a",
                     result_valid, result_hit, result_candidate);
        else n_pass++;
        enable = 1'b0;
        step();
        n_checks++;
        if (result_hit !== 1'b0 || result_candidate !== 32'd0 || busy !== 1'b0)
            $display("FAIL hit1_idle: hit %b cand %h busy %b want 0 0 0",
                     result_hit, result_candidate, busy);
        else n_pass++;
    endtask

    task automatic test_multi_hit();
        bit ok;
        apply_reset();
        enable = 1'b1;
        step();
        wait_issue(4'd3, ok);
        n_checks++;
        if (!ok) $display("FAIL multi_issue_timeout: base 3 never issued");
        else n_pass++;
        repeat (4) step();
        found_vec = 8'b1001_0000;
        step();
        found_vec = '0;
        n_checks++;
        if (result_valid !== 1'b1 || result_hit !== 1'b1 || result_candidate !== 32'h0000_001C ||
            multi_hit !== 1'b1)
            $display("FAIL multi_result: valid %b hit %b cand %h multi %b want 1 1 0000001c 1",
                     result_valid, result_hit, result_candidate, multi_hit);
        else n_pass++;
    endtask

    task automatic test_exhaust();
        int  cyc;
        int  n_issued;
        int  nd;
        bit  order_ok;
        bit  drain_quiet;
        apply_reset();
        enable      = 1'b1;
        step();
        cyc         = 0;
        n_issued    = 0;
        order_ok    = 1'b1;
        drain_quiet = 1'b1;
        while (!draining && cyc < 40) begin
            if (issue_valid) begin
                if (base_out !== n_issued[BW-1:0]) order_ok = 1'b0;
                n_issued++;
            end
            step();
            cyc++;
        end
        n_checks++;
        if (n_issued != 16 || !order_ok)
            $display("FAIL exhaust_issues: count %0d in_order %b want 16 1", n_issued, order_ok);
        else n_pass++;
        nd = 0;
        while (draining && nd < 20) begin
            if (issue_valid) drain_quiet = 1'b0;
            nd++;
            step();
        end
        n_checks++;
        if (nd != 4 || !drain_quiet)
            $display("FAIL exhaust_drain: cycles %0d quiet %b want 4 1", nd, drain_quiet);
        else n_pass++;
        n_checks++;
        if (result_valid !== 1'b1 || result_hit !== 1'b0 || result_candidate !== 32'd0)
            $display("FAIL exhaust_result: valid %b hit %b cand %h want 1 0 00000000",
                     result_valid, result_hit, result_candidate);
        else n_pass++;
    endtask

    task automatic test_drain_hit();
        bit ok;
        apply_reset();
        enable = 1'b1;
        step();
        wait_issue(4'd15, ok);
        n_checks++;
        if (!ok) $display("FAIL drainhit_issue_timeout: base 15 never issued");
        else n_pass++;
        repeat (4) step();
        n_checks++;
        if (draining !== 1'b1 || issue_valid !== 1'b0)
            $display("FAIL drainhit_state: draining %b issue %b want 1 0", draining, issue_valid);
        else n_pass++;
        found_vec = 8'b0010_0000;
        step();
        found_vec = '0;
        n_checks++;
        if (result_valid !== 1'b1 || result_hit !== 1'b1 || result_candidate !== 32'h0000_007D)
            $display("FAIL drainhit_result: valid %b hit %b cand %h want 1 1 0000007d",
                     result_valid, result_hit, result_candidate);
        else n_pass++;
    endtask

    task automatic test_pause();
        bit ok;
        bit pause_ok;
        apply_reset();
        enable = 1'b1;
        step();
        wait_issue(4'd8, ok);
        n_checks++;
        if (!ok) $display("FAIL pause_issue_timeout: base 8 never issued");
        else n_pass++;
        enable   = 1'b0;
        pause_ok = 1'b1;
        repeat (10) begin
            step();
            if (base_out !== 4'd9 || issue_valid !== 1'b0 || paused !== 1'b1) pause_ok = 1'b0;
        end
        n_checks++;
        if (!pause_ok)
            $display("FAIL pause_hold: base %0d issue %b paused %b want 9 0 1",
                     base_out, issue_valid, paused);
        else n_pass++;
        enable = 1'b1;
        step();
        n_checks++;
        if (base_out !== 4'd9 || issue_valid !== 1'b1 || paused !== 1'b0)
            $display("FAIL pause_resume: base %0d issue %b paused %b want 9 1 0",
                     base_out, issue_valid, paused);
        else n_pass++;
        step();
        n_checks++;
        if (base_out !== 4'd10 || issue_valid !== 1'b1)
            $display("FAIL pause_next: base %0d issue %b want 10 1", base_out, issue_valid);
        else n_pass++;
    endtask

    task automatic test_pause_hit();
        bit ok;
        apply_reset();
        enable = 1'b1;
        step();
        wait_issue(4'd8, ok);
        n_checks++;
        if (!ok) $display("FAIL pausehit_issue_timeout: base 8 never issued");
        else n_pass++;
        enable = 1'b0;
        repeat (4) step();
        n_checks++;
        if (paused !== 1'b1) $display("FAIL pausehit_state: paused %b want 1", paused);
        else n_pass++;
        found_vec = 8'b0000_0010;
        step();
        found_vec = '0;
        n_checks++;
        if (result_valid !== 1'b1 || result_hit !== 1'b1 || result_candidate !== 32'h0000_0041 ||
            multi_hit !== 1'b0)
            $display("FAIL pausehit_result: valid %b hit %b cand %h multi %b want 1 1 00000041 0",
                     result_valid, result_hit, result_candidate, multi_hit);
        else n_pass++;
    endtask

    task automatic test_spurious();
        apply_reset();
        enable = 1'b1;
        step();
        found_vec = 8'hFF;
        repeat (3) step();
        found_vec = '0;
        n_checks++;
        if (spurious_cnt !== 8'd3) $display("FAIL spur_count: got %0d want 3", spurious_cnt);
        else n_pass++;
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b1 || issue_valid !== 1'b1 || base_out !== 4'd3)
            $display("FAIL spur_run: valid %b busy %b issue %b base %0d want 0 1 1 3",
                     result_valid, busy, issue_valid, base_out);
        else n_pass++;
    endtask

    task automatic test_reset_in_drain();
        bit ok;
        apply_reset();
        enable = 1'b1;
        step();
        wait_issue(4'd15, ok);
        n_checks++;
        if (!ok) $display("FAIL rstdrain_issue_timeout: base 15 never issued");
        else n_pass++;
        step();
        n_checks++;
        if (draining !== 1'b1) $display("FAIL rstdrain_state: draining %b want 1", draining);
        else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || draining !== 1'b0 || issue_valid !== 1'b0 || base_out !== 4'd0)
            $display("FAIL rstdrain_idle: busy %b draining %b issue %b base %0d want 0 0 0 0",
                     busy, draining, issue_valid, base_out);
        else n_pass++;
        reset = 1'b0;
        step();
        found_vec = 8'b0000_0001;
        step();
        step();
        found_vec = '0;
        n_checks++;
        if (result_valid !== 1'b0 || spurious_cnt !== 8'd2)
            $display("FAIL rstdrain_stale: valid %b spur %0d want 0 2", result_valid, spurious_cnt);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1 || issue_valid !== 1'b1 || base_out !== 4'd2)
            $display("FAIL rstdrain_run: busy %b issue %b base %0d want 1 1 2",
                     busy, issue_valid, base_out);
        else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        found_vec    = '0;
        result_ready = 1'b0;
        test_reset();
        test_hit_single();
        test_multi_hit();
        test_exhaust();
        test_drain_hit();
        test_pause();
        test_pause_hit();
        test_spurious();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
